wakeup_queue: RTL
=================

# wakeup_queue

Wakeup-side receiver for the dispatch/wakeup handshake. Accepts dispatched instructions whose not-ready sources are named by producer location ({FU index, column index}), holds them in a small slot array, and clears each source when a matching writeback location is broadcast. It presents one ready slot per cycle to the select/issue stage and drives `entry_free` back to Dispatch.

## Interface
- `NUM_ENTRIES`, 8: slot count, power of two, ≥2.
- `NUM_FUS`, `NUM_COLS`: from `CORE_PKG`, not overridden locally.
- `LOC_W`, `$clog2(NUM_FUS)+$clog2(NUM_COLS)`: location width, `loc = {fu, col}`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `entry_free`  out  1  at least one slot is free.
- `dispatch_valid`  in  1  dispatch instruction valid.
- `src1_dp_en` / `src2_dp_en`  in  1  source is waiting on a producer; 0 means ready.
- `src1_dp_loc` / `src2_dp_loc`  in  LOC_W  producer location; ignored when the matching `_en` is 0.
- `dst_loc`  in  LOC_W  location this instruction will occupy when it executes.
- `wake_valid`  in  NUM_FUS  per-FU writeback broadcast.
- `wake_col`  in  NUM_FUS×$clog2(NUM_COLS)  column for each broadcasting FU.
- `flush`  in  1  synchronous squash of all slots.
- `issue_valid`  out  1  a slot with all sources ready is presented.
- `issue_idx`  out  $clog2(NUM_ENTRIES)  presented slot index.
- `issue_dst_loc`  out  LOC_W  `dst_loc` of the presented slot.
- `issue_ack`  in  1  select consumed the presented slot.

## Operation
- Each slot holds `valid`, `s1_wait`, `s2_wait`, `s1_loc`, `s2_loc`, `dst_loc`.
- `entry_free = |~valid`. It is computed from registered state only, with no path from `dispatch_valid`.
- **Dispatch accept:** when `dispatch_valid && entry_free`, write into the lowest-index free slot. Set `sN_wait = srcN_dp_en`, except that it is cleared if a same-cycle wakeup matches `srcN_dp_loc` (bypass is mandatory).
- **Dispatch while full:** `dispatch_valid` is ignored, with no state change. Dispatch must hold the instruction.
- **Wakeup:** for every FU f with `wake_valid[f]`, each valid slot with `sN_wait && sN_loc == {f, wake_col[f]}` clears `sN_wait`. Multiple FUs may broadcast in the same cycle, and each is matched independently.
- **Ready:** a slot is ready when `valid && !s1_wait && !s2_wait`. Select picks the lowest-index ready slot (age order under the macro below).
- **Issue:** `issue_valid && issue_ack` clears `valid` of `issue_idx` at the edge. `issue_ack` without `issue_valid` is ignored.
- **Flush:** clears all `valid` bits. It has priority over dispatch and issue in the same cycle, so nothing is written.

## Timing
- **Reset values:** `valid` = 0 for all slots, `entry_free` = 1, `issue_valid` = 0, `issue_idx` = 0, `issue_dst_loc` = 0.
- **Issue outputs:** combinational from registered slot state. They never depend combinationally on `wake_valid` or dispatch inputs.
- **Dispatch to issue:**
  - A slot dispatched with both sources ready (or bypassed) is presentable the cycle after acceptance, i.e. latency 1.
  - A wakeup in cycle N makes its consumer presentable in N+1.
- **Freed slot reuse:** a slot freed by issue in cycle N raises `entry_free` in N+1 at the earliest. It is not reused for a dispatch accepted in cycle N.
- **Wrap-around:** none, because slots are position-indexed. Any slot may be reused in any order.
- **Reset mid-operation:** all slots are dropped immediately (asynchronous). Outputs take their reset values.

## Configuration
- `WAKEUP_AGE_ORDER_EN` defined: select presents the oldest ready slot, tracked by an N×N age matrix.
  - On dispatch, the new row is set to "older than me" for every currently valid slot.
  - Row and column are cleared on issue and on flush.
- `WAKEUP_AGE_ORDER_EN` undefined: lowest-index ready slot, and no age storage is built.

## Structure
- **`CORE_PKG`:** `NUM_FUS`, `NUM_COLS`, the `LOC_W` constant, and the `wakeup_slot_t` packed struct (valid, waits, locs, dst).
- **`wakeup_age_matrix` sub-module:** age bookkeeping and oldest-ready pick.
  - Ports: alloc one-hot, free one-hot, flush, ready vector, pick one-hot.
  - Instantiated only under the macro.

## Test plan
- **Reset and ready dispatch:** assert `rst`, then dispatch with `src1_dp_en = src2_dp_en = 0` and `dst_loc = 5`.
  - Expect `entry_free` = 1 during reset.
  - Next cycle: `issue_valid` = 1, `issue_idx` = 0, `issue_dst_loc` = 5.
  - Ack, then `issue_valid` = 0.
- **Single wakeup:** dispatch with `src1_dp_en` = 1, `src1_dp_loc = {fu 1, col 2}`.
  - `issue_valid` stays 0.
  - Drive `wake_valid[1]` = 1, `wake_col[1]` = 2.
  - Next cycle: `issue_valid` = 1.
- **Same-cycle bypass:** dispatch waiting on `{0,3}` in the same cycle as `wake_valid[0]` with col 3.
  - `issue_valid` = 1 on the next cycle.
- **Full and stalled:** fill 8 slots waiting on `{2,0}` (not-ready).
  - `entry_free` = 0; a 9th dispatch is ignored.
  - Broadcast `{2,0}` and ack one issue; `entry_free` = 1 the cycle after.
- **Flush priority:** assert `flush` with `dispatch_valid` in the same cycle, 3 slots valid.
  - Next cycle: all empty, `issue_valid` = 0.
- **Age order (macro on):** dispatch A into slot 0, then B into slot 1, with both waiting on `{0,0}` and `{1,0}` respectively.
  - Broadcast B's producer first, then A's.
  - Free slot 0, re-dispatch C (ready) into slot 0.
  - Expect pick order B, A, C. Expect lowest index first with the macro off.

Source files
------------

// File: rtl/wakeup_queue_pkg.sv
// Core parameters, location encoding and slot payload shared by the wakeup queue.
// Locations are {fu, col}; a writeback on FU f at column c wakes location {f, c}.
package wakeup_queue_pkg;

  localparam int unsigned NUM_FUS  = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned FU_W     = $clog2(NUM_FUS);
  localparam int unsigned COL_W    = $clog2(NUM_COLS);
  localparam int unsigned LOC_W    = FU_W + COL_W;

  typedef logic [LOC_W-1:0] loc_t;

  typedef struct packed {
    logic valid;
    logic s1_wait;
    logic s2_wait;
    loc_t s1_loc;
    loc_t s2_loc;
    loc_t dst_loc;
  } wakeup_slot_t;

  // True when any broadcasting FU names this location this cycle.
  function automatic logic loc_woken(input loc_t loc,
                                     input logic [NUM_FUS-1:0] wv,
                                     input logic [NUM_FUS-1:0][COL_W-1:0] wc);
    logic hit;
    hit = 1'b0;
    for (int unsigned f = 0; f < NUM_FUS; f++) begin
      if (wv[f] && (loc == {FU_W'(f), wc[f]})) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/wakeup_queue_if.sv
// Dispatch / wakeup / issue bundle between the dispatch-select side (master) and the queue (slave).
interface wakeup_queue_if
  import wakeup_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  logic                           entry_free;
  logic                           dispatch_valid;
  logic                           src1_dp_en;
  logic                           src2_dp_en;
  loc_t                           src1_dp_loc;
  loc_t                           src2_dp_loc;
  loc_t                           dst_loc;
  logic [NUM_FUS-1:0]             wake_valid;
  logic [NUM_FUS-1:0][COL_W-1:0]  wake_col;
  logic                           flush;
  logic                           issue_valid;
  logic [IDX_W-1:0]               issue_idx;
  loc_t                           issue_dst_loc;
  logic                           issue_ack;

  modport master (
    input  entry_free, issue_valid, issue_idx, issue_dst_loc,
    output dispatch_valid, src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc, dst_loc,
           wake_valid, wake_col, flush, issue_ack
  );

  modport slave (
    output entry_free, issue_valid, issue_idx, issue_dst_loc,
    input  dispatch_valid, src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc, dst_loc,
           wake_valid, wake_col, flush, issue_ack
  );

endinterface

// File: rtl/wakeup_queue_age_matrix.sv
// Age bookkeeping and oldest-ready pick; only built when WAKEUP_AGE_ORDER_EN is defined.
// age[i][j] = 1 means slot j is older than slot i.
`ifdef WAKEUP_AGE_ORDER_EN
module wakeup_age_matrix #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic         flush,
  input  logic [N-1:0] ready,
  output logic [N-1:0] pick
);

  logic [N-1:0] age [N];

  // A new row marks every other slot older; stale bits toward empty slots are
  // harmless (empty slots are never ready) and the column is cleared on reuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(N); i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          if (free[i] || free[j] || alloc[j]) age[i][j] <= 1'b0;
          else if (alloc[i])                  age[i][j] <= (i != j);
        end
      end
    end
  end

  // Oldest ready: ready with no older slot also ready.
  always_comb begin
    pick = '0;
    for (int i = 0; i < int'(N); i++) begin
      pick[i] = ready[i] && ((age[i] & ready) == '0);
    end
  end

endmodule
`endif

// File: rtl/wakeup_queue.sv
// Wakeup queue: holds dispatched instructions until their producer locations are broadcast,
// then presents one ready slot per cycle. WAKEUP_AGE_ORDER_EN selects oldest-first picking.
module wakeup_queue
  import wakeup_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input logic clk,
  input logic rst,
  wakeup_queue_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  wakeup_slot_t             slots [NUM_ENTRIES];
  wakeup_slot_t             new_slot;
  logic [NUM_ENTRIES-1:0]   ready_vec;
  logic [NUM_ENTRIES-1:0]   free_vec;
  logic [NUM_ENTRIES-1:0]   alloc_oh;
  logic [NUM_ENTRIES-1:0]   pick_oh;
  logic [NUM_ENTRIES-1:0]   free_oh;
  logic [NUM_ENTRIES-1:0]   s1_hit;
  logic [NUM_ENTRIES-1:0]   s2_hit;
  logic                     dispatch_fire;
  logic                     issue_fire;
  logic [IDX_W-1:0]         pick_idx;
  loc_t                     pick_dst;

  // Slot status derived purely from registered state.
  always_comb begin
    ready_vec = '0;
    free_vec  = '0;
    s1_hit    = '0;
    s2_hit    = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      ready_vec[i] = slots[i].valid && !slots[i].s1_wait && !slots[i].s2_wait;
      free_vec[i]  = !slots[i].valid;
      s1_hit[i]    = slots[i].s1_wait && loc_woken(slots[i].s1_loc, bus.wake_valid, bus.wake_col);
      s2_hit[i]    = slots[i].s2_wait && loc_woken(slots[i].s2_loc, bus.wake_valid, bus.wake_col);
    end
  end

  assign alloc_oh = free_vec & (~free_vec + NUM_ENTRIES'(1));

`ifdef WAKEUP_AGE_ORDER_EN
  wakeup_age_matrix #(.N(NUM_ENTRIES)) u_age (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc_oh & {NUM_ENTRIES{dispatch_fire}}),
    .free  (free_oh),
    .flush (bus.flush),
    .ready (ready_vec),
    .pick  (pick_oh)
  );
`else
  assign pick_oh = ready_vec & (~ready_vec + NUM_ENTRIES'(1));
`endif

  always_comb begin
    pick_idx = '0;
    pick_dst = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (pick_oh[i]) begin
        pick_idx = pick_idx | IDX_W'(i);
        pick_dst = pick_dst | slots[i].dst_loc;
      end
    end
  end

  assign bus.entry_free    = |free_vec;
  assign bus.issue_valid   = |ready_vec;
  assign bus.issue_idx     = pick_idx;
  assign bus.issue_dst_loc = pick_dst;

  assign dispatch_fire = bus.dispatch_valid && bus.entry_free;
  assign issue_fire    = bus.issue_valid && bus.issue_ack;
  assign free_oh       = pick_oh & {NUM_ENTRIES{issue_fire}};

  // Incoming payload, with same-cycle wakeups bypassed into the wait bits.
  always_comb begin
    new_slot         = '0;
    new_slot.valid   = 1'b1;
    new_slot.s1_wait = bus.src1_dp_en && !loc_woken(bus.src1_dp_loc, bus.wake_valid, bus.wake_col);
    new_slot.s2_wait = bus.src2_dp_en && !loc_woken(bus.src2_dp_loc, bus.wake_valid, bus.wake_col);
    new_slot.s1_loc  = bus.src1_dp_loc;
    new_slot.s2_loc  = bus.src2_dp_loc;
    new_slot.dst_loc = bus.dst_loc;
  end

  // Flush wins over dispatch and issue; the allocated slot is always empty, the issued one valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) slots[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) slots[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (dispatch_fire && alloc_oh[i]) begin
          slots[i] <= new_slot;
        end else if (slots[i].valid) begin
          if (free_oh[i]) slots[i].valid   <= 1'b0;
          if (s1_hit[i])  slots[i].s1_wait <= 1'b0;
          if (s2_hit[i])  slots[i].s2_wait <= 1'b0;
        end
      end
    end
  end

endmodule
